// File: rtl/dft_pkg.sv
// Shared defaults, FSM state type and bit-reverse helper
// for the bit-reversed pair buffer feeding a radix-2 butterfly.
package dft_pkg;

  localparam int WORD_SZ_DEF  = 8;
  localparam int N_POINTS_DEF = 8;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  // Reverse the low nbits of v; upper bits of the result are zero.
  function automatic logic [31:0] bitrev(
    input logic [31:0] v,
    input int          nbits
  );
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < nbits; i++) begin
      r[i] = v[nbits-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/dft_sample_ram.sv
// Frame store: N x W, one sync write port, two async reads.
// Ports: clk, we/waddr/wdata write; raddr1/2 -> rdata1/2 read.
module dft_sample_ram #(
  parameter int W  = 8,
  parameter int N  = 8,
  parameter int AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr1,
  input  logic [AW-1:0] raddr2,
  output logic [W-1:0]  rdata1,
  output logic [W-1:0]  rdata2
);

  logic [W-1:0] mem [N];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata1 = mem[raddr1];
  assign rdata2 = mem[raddr2];

endmodule

// File: rtl/bitrev_pair_buffer.sv
// Buffers one natural-order frame, then emits bit-reversed
// operand pairs (out1/out2) with valid/ready on both sides.
module bitrev_pair_buffer
  import dft_pkg::*;
#(
  parameter int WORD_SZ  = WORD_SZ_DEF,
  parameter int N_POINTS = N_POINTS_DEF
) (
  input  logic               i_CLK,
  input  logic               i_RESET,
  input  logic [WORD_SZ-1:0] i_sample,
  input  logic               i_valid,
  output logic               o_ready,
  output logic [WORD_SZ-1:0] o_out1,
  output logic [WORD_SZ-1:0] o_out2,
  output logic               o_valid,
  input  logic               i_ready,
  output logic               o_frame_last
);

  localparam int AW = $clog2(N_POINTS);
  localparam int PW = AW - 1;
  localparam logic [AW-1:0] WLAST = AW'(N_POINTS - 1);
  localparam logic [PW-1:0] PLAST = PW'(N_POINTS / 2 - 1);

  state_t state_q, state_d;

  logic [AW-1:0]      wr_cnt;
  logic [PW-1:0]      rd_cnt;
  logic [PW-1:0]      nxt;
  logic               wr_en;
  logic               in_last;
  logic               out_hs;
  logic               load;
  logic [AW-1:0]      ra1;
  logic [AW-1:0]      ra2;
  logic [WORD_SZ-1:0] rd1;
  logic [WORD_SZ-1:0] rd2;

  assign o_ready = (state_q == FILL) && !i_RESET;
  assign wr_en   = i_valid && o_ready;
  assign in_last = wr_en && (wr_cnt == WLAST);
  assign out_hs  = o_valid && i_ready;

  // Pair 0 only needs mem[0] and mem[N/2], both written
  // before the final sample, so it can load on that edge.
  assign ra1 = AW'(bitrev(32'({nxt, 1'b0}), AW));
  assign ra2 = AW'(bitrev(32'({nxt, 1'b1}), AW));

  dft_sample_ram #(
    .W (WORD_SZ),
    .N (N_POINTS),
    .AW(AW)
  ) u_ram (
    .clk   (i_CLK),
    .we    (wr_en),
    .waddr (wr_cnt),
    .wdata (i_sample),
    .raddr1(ra1),
    .raddr2(ra2),
    .rdata1(rd1),
    .rdata2(rd2)
  );

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    nxt     = '0;
    unique case (state_q)
      FILL: begin
        if (in_last) begin
          state_d = DRAIN;
          load    = 1'b1;
        end
      end
      DRAIN: begin
        nxt = rd_cnt + 1'b1;
        if (out_hs) begin
          if (rd_cnt == PLAST) begin
            state_d = FILL;
          end else begin
            load = 1'b1;
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      wr_cnt       <= '0;
      rd_cnt       <= '0;
      o_valid      <= 1'b0;
      o_out1       <= '0;
      o_out2       <= '0;
      o_frame_last <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_cnt <= in_last ? '0 : wr_cnt + 1'b1;
      end
      if (load) begin
        o_out1       <= rd1;
        o_out2       <= rd2;
        o_valid      <= 1'b1;
        o_frame_last <= (nxt == PLAST);
        rd_cnt       <= nxt;
      end else if (out_hs) begin
        // only reached on the last pair of the frame
        o_valid      <= 1'b0;
        o_frame_last <= 1'b0;
        rd_cnt       <= '0;
      end
    end
  end

endmodule

// File: tb/tb_bitrev_pair_buffer.sv
// Directed bench for bitrev_pair_buffer with an expected-pair
// queue filled at stimulus time and drained by a monitor.
module tb_bitrev_pair_buffer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] smp = '0;
  logic       vin = 1'b0;
  logic       rdy_o;
  logic [7:0] out1;
  logic [7:0] out2;
  logic       vout;
  logic       rdy_i = 1'b1;
  logic       flast;

  int ncmp = 0;
  int nbad = 0;

  logic [16:0] expq [$];
  logic [16:0] held;
  logic        hold_armed = 1'b0;
  logic        junk = 1'b0;

  int ord [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

  always #5 clk = ~clk;

  bitrev_pair_buffer #(
    .WORD_SZ (8),
    .N_POINTS(8)
  ) dut (
    .i_CLK       (clk),
    .i_RESET     (rst),
    .i_sample    (smp),
    .i_valid     (vin),
    .o_ready     (rdy_o),
    .o_out1      (out1),
    .o_out2      (out2),
    .o_valid     (vout),
    .i_ready     (rdy_i),
    .o_frame_last(flast)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp)
    else begin
      nbad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] xs(input int k, input logic [7:0] base);
    logic [7:0] kk;
    kk = 8'(k);
    return {kk[3:0], 4'h1} + base;
  endfunction

  // Monitor: pop/compare on each output handshake and check
  // that a stalled pair holds until it is taken.
  always @(negedge clk) begin
    if (!rst) begin
      if (hold_armed && vout) begin
        chk("hold", {15'd0, out1, out2, flast}, {15'd0, held});
      end
      hold_armed = vout && !rdy_i;
      held = {out1, out2, flast};
      if (vout && rdy_i) begin
        if (expq.size() == 0) begin
          chk("unexpected_pair", {15'd0, out1, out2, flast}, 32'hFFFF_FFFF);
        end else begin
          chk("pair", {15'd0, out1, out2, flast}, {15'd0, expq.pop_front()});
        end
      end
    end else begin
      hold_armed = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input logic [7:0] base);
    for (int j = 0; j < 4; j++) begin
      expq.push_back({xs(ord[2*j], base), xs(ord[2*j+1], base), (j == 3)});
    end
  endtask

  // gap = idle cycles inserted after every sample but the last
  task automatic send(input int n, input logic [7:0] base, input int gap);
    for (int k = 0; k < n; k++) begin
      smp = xs(k, base);
      vin = 1'b1;
      step();
      vin = 1'b0;
      smp = '0;
      if (k != 7) begin
        repeat (gap) step();
      end
    end
  endtask

  task automatic frame(input logic [7:0] base, input int gap);
    push_frame(base);
    send(8, base, gap);
    chk("latency_valid", {31'd0, vout}, 32'd1);
    if (junk) begin
      vin = 1'b1;
      smp = 8'hFF;
    end
  endtask

  task automatic drain(input string tag);
    for (int c = 0; c < 40 && expq.size() != 0; c++) begin
      if (junk) begin
        chk("drain_ready", {31'd0, rdy_o}, 32'd0);
      end
      step();
    end
    vin = 1'b0;
    smp = '0;
    chk({tag, "_empty"}, 32'(expq.size()), 32'd0);
    chk({tag, "_ready_after"}, {31'd0, rdy_o}, 32'd1);
    chk({tag, "_valid_after"}, {31'd0, vout}, 32'd0);
  endtask

  initial begin
    step();
    chk("rst_ready", {31'd0, rdy_o}, 32'd0);
    chk("rst_valid", {31'd0, vout}, 32'd0);
    chk("rst_outs", {15'd0, out1, out2, flast}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rel_ready", {31'd0, rdy_o}, 32'd1);

    // back-to-back fill, free-flowing output
    frame(8'h00, 0);
    drain("b2b");

    // consecutive frame, different data
    frame(8'h02, 0);
    drain("consec");

    // backpressure on pair 1
    frame(8'h00, 0);
    step();
    chk("bp_pair1", {16'd0, out1, out2}, 32'h2161);
    rdy_i = 1'b0;
    repeat (3) step();
    rdy_i = 1'b1;
    drain("bp");

    // sparse input valid
    frame(8'h00, 2);
    drain("gaps");

    // junk input during drain
    junk = 1'b1;
    frame(8'h00, 0);
    drain("junk");
    junk = 1'b0;
    frame(8'h04, 0);
    drain("after_junk");

    // reset mid-fill then a fresh frame
    send(5, 8'h00, 0);
    rst = 1'b1;
    #1;
    chk("midrst_ready", {31'd0, rdy_o}, 32'd0);
    step();
    rst = 1'b0;
    #1;
    chk("midrst_valid", {31'd0, vout}, 32'd0);
    frame(8'h08, 0);
    drain("midrst");

    // reset mid-drain abandons the frame
    frame(8'h00, 0);
    step();
    rst = 1'b1;
    expq.delete();
    step();
    rst = 1'b0;
    #1;
    chk("drainrst_valid", {31'd0, vout}, 32'd0);
    frame(8'h08, 0);
    drain("drainrst");

    repeat (3) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule

// File: doc/bitrev_pair_buffer.md
BITREV_PAIR_BUFFER -- requirements
Module: bitrev_pair_buffer

Interface
REQ-001 Parameter WORD_SZ, default 8: sample width; upper WORD_SZ/2 bits are the real part, lower WORD_SZ/2 bits are the imaginary part.
REQ-002 Parameter N_POINTS, default 8: frame length; SHALL be a power of two and at least 4.
REQ-003 Port i_CLK, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port i_RESET, input, 1: reset; synchronous and active-high.
REQ-005 Port i_sample, input, WORD_SZ: upstream complex sample in natural order.
REQ-006 Port i_valid, input, 1: i_sample is valid.
REQ-007 Port o_ready, output, 1: block accepts a sample this cycle.
REQ-008 Port o_out1, output, WORD_SZ: first butterfly operand (feeds butterfly in1).
REQ-009 Port o_out2, output, WORD_SZ: second butterfly operand (feeds butterfly in2).
REQ-010 Port o_valid, output, 1: o_out1/o_out2 hold a valid pair.
REQ-011 Port i_ready, input, 1: downstream butterfly accepts the pair.
REQ-012 Port o_frame_last, output, 1: the current pair is the last pair of the frame.

Function
REQ-013 Two states: FILL and DRAIN.
REQ-014 FILL: o_ready=1; a handshake (i_valid & o_ready) writes i_sample to mem[wr_cnt] and increments wr_cnt.
REQ-015 FILL: on the handshake with wr_cnt = N_POINTS-1, the state moves to DRAIN, wr_cnt wraps to 0, and pair 0 is loaded into the output registers on the same edge.
REQ-016 Pair j (j = 0..N_POINTS/2-1) SHALL be o_out1 = mem[bitrev(2j)] and o_out2 = mem[bitrev(2j+1)], with bitrev taken over log2(N_POINTS) bits.
REQ-017 Pair ordering for N=8: (x0,x4), (x2,x6), (x1,x5), (x3,x7).
REQ-018 Latency: o_valid SHALL rise on the cycle immediately after the last sample handshake.
REQ-019 DRAIN: o_ready=0; i_valid and i_sample are ignored and no write occurs.
REQ-020 Output handshake (o_valid & i_ready) advances rd_cnt and loads the next pair on the same edge; throughput is one pair per cycle.
REQ-021 While o_valid=1 and i_ready=0, o_out1, o_out2 and o_frame_last SHALL hold stable.
REQ-022 o_frame_last=1 exactly when o_valid=1 and rd_cnt = N_POINTS/2-1.
REQ-023 On the handshake of the last pair: o_valid falls, rd_cnt wraps to 0, the state moves to FILL, and o_ready=1 on the next cycle.
REQ-024 Samples are passed through bit-exact; there is no arithmetic, rounding or width change.
REQ-025 Gaps in i_valid SHALL NOT affect the fill order or the stored data.

Reset
REQ-026 While i_RESET=1 at a rising edge, the following SHALL be cleared: state=FILL, wr_cnt=0, rd_cnt=0, o_valid=0, o_out1=0, o_out2=0, o_frame_last=0.
REQ-027 o_ready SHALL be 0 during any cycle with i_RESET=1, and 1 on the first cycle after release.
REQ-028 Reset mid-frame (FILL or DRAIN) abandons the partial frame; stale mem contents need not be cleared and SHALL never be emitted.

Structure
REQ-029 Package dft_pkg SHALL hold:
- the default WORD_SZ and N_POINTS;
- the state enum {FILL, DRAIN};
- the bitrev function, parameterised by bit count.
REQ-030 Sub-module dft_sample_ram SHALL provide N_POINTS x WORD_SZ storage: one write port and two asynchronous read ports, no reset.
REQ-031 The control FSM, counters and output registers SHALL reside in bitrev_pair_buffer.

Verification
Samples below are x_k = {re=k, im=1}, i.e. 0x01, 0x11, ..., 0x71.
REQ-032 Back-to-back fill:
- stimulus: x0..x7 on 8 consecutive cycles, i_ready=1;
- response: pairs (01,41), (21,61), (11,51), (31,71) on 4 consecutive cycles, starting the cycle after x7;
- o_frame_last=1 on the 4th pair only.
REQ-033 Backpressure:
- stimulus: i_ready=0 for 3 cycles while pair (21,61) is presented;
- response: outputs held for 3 cycles, no pair skipped or repeated.
REQ-034 Input gaps:
- stimulus: i_valid toggled 1,0,0,1,... across the frame;
- response: identical pair sequence to REQ-032.
REQ-035 DRAIN ignore:
- stimulus: i_valid=1 with i_sample=0xFF throughout DRAIN;
- response: o_ready=0, and the next frame's pairs are unaffected.
REQ-036 Reset mid-fill:
- stimulus: i_RESET pulsed after 5 samples, then a full frame of x_k+0x08;
- response: pairs (09,49), (29,69), (19,59), (39,79) only.
REQ-037 Consecutive frames:
- response: o_ready=1 on the cycle after the last-pair handshake;
- the second frame drains correctly with no residue from the first.
